// File: rtl/sha3_pkg.sv
// Shared types, rate constants and helpers for the SHA-3 pad/absorb stage.
package sha3_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [0:24] state_t;

  typedef enum logic [2:0] {
    MODE_SHA3_224 = 3'd0,
    MODE_SHA3_256 = 3'd1,
    MODE_SHA3_384 = 3'd2,
    MODE_SHA3_512 = 3'd3,
    MODE_SHAKE128 = 3'd4,
    MODE_SHAKE256 = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_EXTRA = 2'd2,
    ST_HOLD  = 2'd3
  } fsm_e;

  localparam logic [4:0] RATE_224  = 5'd18;
  localparam logic [4:0] RATE_256  = 5'd17;
  localparam logic [4:0] RATE_384  = 5'd13;
  localparam logic [4:0] RATE_512  = 5'd9;
  localparam logic [4:0] RATE_S128 = 5'd21;
  localparam logic [4:0] RATE_S256 = 5'd17;

  // Rate in 64-bit lanes; unused encodings fall back to SHA3-256.
  function automatic logic [4:0] rate_lanes(input mode_e m);
    case (m)
      MODE_SHA3_224: rate_lanes = RATE_224;
      MODE_SHA3_256: rate_lanes = RATE_256;
      MODE_SHA3_384: rate_lanes = RATE_384;
      MODE_SHA3_512: rate_lanes = RATE_512;
      MODE_SHAKE128: rate_lanes = RATE_S128;
      MODE_SHAKE256: rate_lanes = RATE_S256;
      default:       rate_lanes = RATE_256;
    endcase
  endfunction

  function automatic logic is_shake(input mode_e m);
    is_shake = (m == MODE_SHAKE128) || (m == MODE_SHAKE256);
  endfunction

  // Number of valid bytes on a final beat: index of the lowest clear keep bit.
  function automatic logic [3:0] keep_count(input logic [7:0] keep);
    keep_count = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (!keep[i]) keep_count = 4'(i);
      else          keep_count = keep_count;
    end
  endfunction

endpackage

// File: rtl/sha3_lane_pad.sv
// Pads one 64-bit lane: keeps bytes below n, writes the domain suffix at
// byte n, clears the rest, and sets the final 0x80 bit when the lane closes
// the rate.
module sha3_lane_pad (
  input  logic [63:0] lane_i,
  input  logic [3:0]  n_i,
  input  logic [7:0]  suffix_i,
  input  logic        is_rate_end_i,
  output logic [63:0] padded_o
);

  // Byte-wise select of data / suffix / zero, then the rate-end marker.
  always_comb begin
    padded_o = 64'h0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < n_i)       padded_o[8*b +: 8] = lane_i[8*b +: 8];
      else if (4'(b) == n_i) padded_o[8*b +: 8] = suffix_i;
      else                   padded_o[8*b +: 8] = 8'h00;
    end
    if (is_rate_end_i) padded_o[63:56] = padded_o[63:56] | 8'h80;
    else               padded_o[63:56] = padded_o[63:56];
  end

endmodule

// File: rtl/sha3_pad_absorb.sv
// SHA-3 / SHAKE pad10*1 and block packer: collects 64-bit AXI-Stream lanes
// into rate-sized Keccak blocks and hands them out over valid/ready.
// Build option: SHA3_PAD_BSWAP_EN byte-reverses S_TDATA/S_TKEEP on entry.
module sha3_pad_absorb
  import sha3_pkg::*;
#(
  parameter logic [7:0] SUFFIX_SHA3  = 8'h06,
  parameter logic [7:0] SUFFIX_SHAKE = 8'h1F,
  parameter int         LANE_W       = 64
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic [2:0]    mode,
  input  logic [63:0]   S_TDATA,
  input  logic [7:0]    S_TKEEP,
  input  logic          S_TVALID,
  input  logic          S_TLAST,
  output logic          S_TREADY,
  output logic [1599:0] block_o,
  output logic [4:0]    block_rate,
  output logic          block_valid,
  output logic          block_last,
  input  logic          block_ready
);

  if (LANE_W != 64) begin : g_lane_w_check
    $error("sha3_pad_absorb: only LANE_W=64 is supported");
  end

  fsm_e        state_q, state_d;
  state_t      lanes_q, lanes_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rate_q, rate_d;
  logic [7:0]  suffix_q, suffix_d;
  logic [4:0]  brate_q, brate_d;
  logic        active_q, active_d;
  logic        extra_q, extra_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        tready_q, tready_d;

  logic [63:0] data_s;
  logic [7:0]  keep_s;
  logic [3:0]  n_s;
  logic [4:0]  eff_rate_s;
  logic [4:0]  rate_end_s;
  logic [7:0]  eff_suffix_s;
  logic        accept_s;
  logic        need_extra_s;
  logic [63:0] padded_s;

  // Input byte order: optional reversal for big-endian hosts.
  always_comb begin
    data_s = S_TDATA;
    keep_s = S_TKEEP;
`ifdef SHA3_PAD_BSWAP_EN
    for (int b = 0; b < 8; b++) begin
      data_s[8*b +: 8] = S_TDATA[56-8*b +: 8];
      keep_s[b]        = S_TKEEP[7-b];
    end
`endif
  end

  // First beat of a message takes rate/suffix straight from mode; later
  // beats use the latched copy so mid-message mode changes are ignored.
  always_comb begin
    if (active_q) begin
      eff_rate_s   = rate_q;
      eff_suffix_s = suffix_q;
    end else begin
      eff_rate_s   = rate_lanes(mode_e'(mode));
      eff_suffix_s = is_shake(mode_e'(mode)) ? SUFFIX_SHAKE : SUFFIX_SHA3;
    end
    rate_end_s   = eff_rate_s - 5'd1;
    n_s          = keep_count(keep_s);
    accept_s     = S_TVALID & tready_q;
    need_extra_s = (n_s == 4'd8) && (cnt_q == rate_end_s);
  end

  sha3_lane_pad u_lane_pad (
    .lane_i        (data_s),
    .n_i           (n_s),
    .suffix_i      (eff_suffix_s),
    .is_rate_end_i ((cnt_q == rate_end_s) && (n_s != 4'd8)),
    .padded_o      (padded_s)
  );

  // Next-state logic: lane fill, padding, extra block and output hold.
  always_comb begin
    state_d  = state_q;
    lanes_d  = lanes_q;
    cnt_d    = cnt_q;
    rate_d   = rate_q;
    suffix_d = suffix_q;
    brate_d  = brate_q;
    active_d = active_q;
    extra_d  = extra_q;
    valid_d  = valid_q;
    last_d   = last_q;
    tready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d  = ST_FILL;
        tready_d = 1'b1;
      end
      ST_FILL: begin
        tready_d = 1'b1;
        if (accept_s) begin
          rate_d   = eff_rate_s;
          suffix_d = eff_suffix_s;
          active_d = ~S_TLAST;
          cnt_d    = cnt_q + 5'd1;
          if (S_TLAST) begin
            lanes_d[cnt_q] = padded_s;
            if (need_extra_s) begin
              // Full final lane at the rate end: padding goes in its own block.
              extra_d = 1'b1;
              last_d  = 1'b0;
            end else begin
              if (n_s == 4'd8) lanes_d[cnt_q + 5'd1] = {56'h0, eff_suffix_s};
              else             lanes_d[cnt_q + 5'd1] = lanes_q[cnt_q + 5'd1];
              lanes_d[rate_end_s][63:56] = lanes_d[rate_end_s][63:56] | 8'h80;
              last_d = 1'b1;
            end
            state_d  = ST_HOLD;
            valid_d  = 1'b1;
            brate_d  = eff_rate_s;
            tready_d = 1'b0;
          end else begin
            lanes_d[cnt_q] = data_s;
            if (cnt_q == rate_end_s) begin
              state_d  = ST_HOLD;
              valid_d  = 1'b1;
              last_d   = 1'b0;
              brate_d  = eff_rate_s;
              tready_d = 1'b0;
            end else begin
              state_d = ST_FILL;
            end
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_EXTRA: begin
        lanes_d    = '0;
        lanes_d[0] = {56'h0, suffix_q};
        lanes_d[rate_q - 5'd1][63:56] = lanes_d[rate_q - 5'd1][63:56] | 8'h80;
        extra_d = 1'b0;
        valid_d = 1'b1;
        last_d  = 1'b1;
        brate_d = rate_q;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (block_ready) begin
          valid_d = 1'b0;
          cnt_d   = 5'd0;
          lanes_d = '0;
          if (extra_q) begin
            state_d = ST_EXTRA;
          end else begin
            state_d  = ST_FILL;
            tready_d = 1'b1;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial block.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      lanes_q  <= '0;
      cnt_q    <= 5'd0;
      rate_q   <= 5'd0;
      suffix_q <= 8'h00;
      brate_q  <= 5'd0;
      active_q <= 1'b0;
      extra_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lanes_q  <= lanes_d;
      cnt_q    <= cnt_d;
      rate_q   <= rate_d;
      suffix_q <= suffix_d;
      brate_q  <= brate_d;
      active_q <= active_d;
      extra_q  <= extra_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      tready_q <= tready_d;
    end
  end

  // Flatten lanes so lane i sits at bits [64i+63:64i].
  always_comb begin
    block_o = '0;
    for (int i = 0; i < 25; i++) block_o[64*i +: 64] = lanes_q[i];
  end

  assign block_rate  = brate_q;
  assign block_valid = valid_q;
  assign block_last  = last_q;
  assign S_TREADY    = tready_q;

endmodule

// File: tb/tb_sha3_pad_absorb.sv
// Self-checking bench for sha3_pad_absorb: a FIPS 202 padding model and
// hand-written vectors feed a block scoreboard checked on each handshake.
module tb_sha3_pad_absorb;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1599:0] blk;
    logic          last;
    logic [4:0]    rate;
  } exp_t;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [2:0]    mode;
  logic [63:0]   S_TDATA;
  logic [7:0]    S_TKEEP;
  logic          S_TVALID;
  logic          S_TLAST;
  logic          S_TREADY;
  logic [1599:0] block_o;
  logic [4:0]    block_rate;
  logic          block_valid;
  logic          block_last;
  logic          block_ready;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   ready_ctl   = 1;

  sha3_pad_absorb dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .mode(mode),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TVALID(S_TVALID),
    .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
    .block_o(block_o), .block_rate(block_rate), .block_valid(block_valid),
    .block_last(block_last), .block_ready(block_ready)
  );

  always #5 ACLK = ~ACLK;

  // block_ready policy: 0 forced low, 1 forced high, otherwise random.
  always @(posedge ACLK) begin
    #1;
    case (ready_ctl)
      0:       block_ready = 1'b0;
      1:       block_ready = 1'b1;
      default: block_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: every accepted block must match the oldest expectation.
  always @(negedge ACLK) begin
    exp_t e;
    int   bad;
    if (ARESETN === 1'b1 && block_valid === 1'b1 && block_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_block: got last=%0b rate=%0d, required no block", block_last, block_rate);
      end else begin
        e   = exp_q.pop_front();
        bad = -1;
        for (int i = 0; i < 25; i++)
          if (bad < 0 && block_o[64*i +: 64] !== e.blk[64*i +: 64]) bad = i;
        if (bad >= 0) begin
          miscompares++;
          $display("FAIL block_lane%0d: got %h required %h", bad, block_o[64*bad +: 64], e.blk[64*bad +: 64]);
        end else if (block_last !== e.last || block_rate !== e.rate) begin
          miscompares++;
          $display("FAIL block_meta: got last=%0b rate=%0d required last=%0b rate=%0d",
                   block_last, block_rate, e.last, e.rate);
        end
      end
    end
  end

  function automatic int rate_of(input int m);
    case (m)
      0: rate_of = 18;
      1: rate_of = 17;
      2: rate_of = 13;
      3: rate_of = 9;
      4: rate_of = 21;
      5: rate_of = 17;
      default: rate_of = 17;
    endcase
  endfunction

  function automatic bq_t rand_bytes(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // FIPS 202 reference: append suffix, zero-fill to the rate, set the top bit.
  task automatic model_push(input int m, input bq_t msg);
    bq_t  p;
    exp_t e;
    int   rb, nblk;
    rb   = 8 * rate_of(m);
    nblk = msg.size() / rb + 1;
    p    = msg;
    p.push_back((m == 4 || m == 5) ? 8'h1F : 8'h06);
    while (p.size() % rb != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    for (int k = 0; k < nblk; k++) begin
      e.blk = '0;
      for (int j = 0; j < rb; j++) e.blk[8*j +: 8] = p[k*rb + j];
      e.last = (k == nblk - 1);
      e.rate = 5'(rate_of(m));
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output bit ok);
    logic rdy;
    int   waited;
    waited = 0;
    ok     = 1'b1;
`ifdef SHA3_PAD_BSWAP_EN
    for (int b = 0; b < 8; b++) begin
      S_TDATA[56-8*b +: 8] = d[8*b +: 8];
      S_TKEEP[7-b]         = k[b];
    end
`else
    S_TDATA = d;
    S_TKEEP = k;
`endif
    S_TLAST  = l;
    S_TVALID = 1'b1;
    do begin
      @(negedge ACLK);
      rdy = S_TREADY;
      @(posedge ACLK);
      waited++;
    end while (rdy !== 1'b1 && waited < 400);
    #1;
    S_TVALID = 1'b0;
    if (rdy !== 1'b1) begin
      ok = 1'b0;
      vectors++;
      miscompares++;
      $display("FAIL beat_accept_timeout: got S_TREADY=%b after %0d cycles, required 1", rdy, waited);
    end
  endtask

  // Sends up to max_beats beats of msg; garbage fills unused bytes and keep bits.
  task automatic send_msg(input int m, input bq_t msg, input int max_beats);
    int          len, beats, n;
    logic [63:0] d;
    logic [7:0]  k, lowmask;
    logic        l;
    bit          ok;
    len   = msg.size();
    beats = (len == 0) ? 1 : (len + 7) / 8;
    for (int b = 0; b < beats && b < max_beats; b++) begin
      l = (b == beats - 1);
      n = l ? len - 8 * b : 8;
      for (int j = 0; j < 8; j++) d[8*j +: 8] = (j < n) ? msg[8*b + j] : 8'($urandom);
      if (n == 8) begin
        k = l ? 8'hFF : 8'($urandom);
      end else begin
        lowmask = 8'hFF >> (8 - n);
        k = lowmask | (8'($urandom) & ~(lowmask | (8'h01 << n)));
      end
      mode = (b == 0) ? 3'(m) : 3'($urandom_range(0, 7));
      drive_beat(d, k, l, ok);
      if (!ok) return;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge ACLK);
      t++;
    end
    @(posedge ACLK);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d blocks outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_empty_256();
    exp_t e;
    e.blk = '0;
    e.blk[63:0]         = 64'h0000000000000006;
    e.blk[64*16 +: 64]  = 64'h8000000000000000;
    e.last = 1'b1;
    e.rate = 5'd17;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (block_o !== 1600'h0 || block_valid !== 1'b0 || block_last !== 1'b0 ||
        block_rate !== 5'd0 || S_TREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got valid=%b last=%b rate=%0d tready=%b block_nonzero=%b, required all 0",
               tag, block_valid, block_last, block_rate, S_TREADY, |block_o);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #2;
    check_all_zero("reset_outputs");
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    vectors++;
    if (S_TREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_tready: got %b required 0", S_TREADY);
    end
    @(posedge ACLK);
    #1;
    vectors++;
    if (S_TREADY !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_tready: got %b required 1", S_TREADY);
    end
  endtask

  task automatic test_empty();
    bq_t q;
    push_empty_256();
    send_msg(1, q, 99);
    drain();
  endtask

  task automatic test_full_rate();
    model_push(1, rand_bytes(136));
    send_msg(1, rand_bytes(0), 0);
    send_msg(1, rand_bytes(0), 0);
    // Re-send with the same bytes the model saw.
    exp_q.delete();
    begin
      bq_t q;
      q = rand_bytes(136);
      model_push(1, q);
      send_msg(1, q, 99);
    end
    drain();
  endtask

  task automatic test_sha3_512_71();
    bq_t  q;
    exp_t e;
    for (int i = 0; i < 71; i++) q.push_back(8'hAA);
    e.blk = '0;
    for (int i = 0; i < 8; i++) e.blk[64*i +: 64] = 64'hAAAAAAAAAAAAAAAA;
    e.blk[64*8 +: 64] = 64'h86AAAAAAAAAAAAAA;
    e.last = 1'b1;
    e.rate = 5'd9;
    exp_q.push_back(e);
    send_msg(3, q, 99);
    drain();
  endtask

  task automatic test_shake128_abc();
    bq_t  q;
    exp_t e;
    q = '{8'h61, 8'h62, 8'h63};
    e.blk = '0;
    e.blk[63:0]        = 64'h000000001F636261;
    e.blk[64*20 +: 64] = 64'h8000000000000000;
    e.last = 1'b1;
    e.rate = 5'd21;
    exp_q.push_back(e);
    send_msg(4, q, 99);
    drain();
  endtask

  task automatic test_spill();
    bq_t q;
    q = rand_bytes(16);
    model_push(2, q);
    send_msg(2, q, 99);
    q = rand_bytes(160);
    model_push(5, q);
    send_msg(5, q, 99);
    drain();
  endtask

  task automatic test_backpressure();
    bq_t  a, b;
    exp_t first;
    int   t;
    a = rand_bytes(136);
    b = rand_bytes(40);
    ready_ctl = 0;
    @(posedge ACLK);
    #2;
    model_push(1, a);
    first = exp_q[0];
    model_push(4, b);
    fork
      begin
        send_msg(1, a, 99);
        send_msg(4, b, 99);
      end
      begin
        t = 0;
        do begin
          @(negedge ACLK);
          t++;
        end while (block_valid !== 1'b1 && t < 400);
        for (int c = 0; c < 10; c++) begin
          vectors++;
          if (block_o !== first.blk || block_last !== first.last || block_rate !== first.rate ||
              block_valid !== 1'b1 || S_TREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got valid=%b tready=%b last=%b rate=%0d lane0=%h, required 1 0 %b %0d %h",
                     c, block_valid, S_TREADY, block_last, block_rate, block_o[63:0],
                     first.last, first.rate, first.blk[63:0]);
          end
          @(negedge ACLK);
        end
        ready_ctl = 1;
      end
    join
    drain();
  endtask

  task automatic test_back_to_back();
    int  lens[13] = '{0, 7, 8, 63, 71, 72, 135, 136, 137, 143, 144, 168, 200};
    bq_t q;
    ready_ctl = 2;
    for (int i = 0; i < 13; i++) begin
      q = rand_bytes(lens[i]);
      model_push(i % 8, q);
      send_msg(i % 8, q, 99);
    end
    drain();
    ready_ctl = 1;
    @(posedge ACLK);
    #2;
  endtask

  task automatic test_reset_mid();
    send_msg(1, rand_bytes(136), 5);
    @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #2;
    push_empty_256();
    send_msg(1, rand_bytes(0), 99);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required summary");
    $fatal(1, "watchdog");
  end

  initial begin
    block_ready = 1'b1;
    S_TVALID    = 1'b0;
    S_TLAST     = 1'b0;
    S_TDATA     = 64'h0;
    S_TKEEP     = 8'h00;
    mode        = 3'd0;
    test_reset();
    test_empty();
    test_full_rate();
    test_sha3_512_71();
    test_shake128_abc();
    test_spill();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
